cordic_output_stage: RTL

CORDIC_OUTPUT_STAGE -- requirements
Module: cordic_output_stage

---
 rtl/cordic_output_stage.sv | 102 ++++++++++
 1 files changed

// File: rtl/cordic_output_stage.sv
// cordic_output_stage: turns raw CORDIC x/y/angle into a sin, cos, tan or angle result with a valid/ready handshake.
// Define CORDIC_OUT_SAT_EN to saturate out-of-range sin/cos/tan results; otherwise they wrap to N bits.
module cordic_output_stage #(
    parameter int N = 32,
    parameter int Q = 16,
    parameter logic [N-1:0] K = 'h0000_9B75
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   select,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] angle,
    input  logic         valid_in,
    output logic         in_ready,
    output logic [N-1:0] CORDIC_OUT,
    output logic         valid_out,
    input  logic         out_ready,
    output logic         div0
);
`ifdef CORDIC_OUT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int CW = $clog2(N + Q);
    localparam logic [CW-1:0] LAST = CW'(N + Q - 1);
    localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nxt;
    logic [N-1:0] op, dvs, rem, rem_nxt, mul_res, div_res;
    logic [N+Q-1:0] quot, quot_nxt;
    logic [N:0] rem_sh, rem_sub;
    logic [2*N-1:0] prod;
    logic [CW-1:0] cnt;
    logic neg, zero, ysgn, ge, mul_ovf, div_ovf, unused;

    assign in_ready = state == IDLE;
    assign valid_out = state == DONE;

    // quot doubles as the dividend shift register; quotient bits enter at the bottom
    always_comb begin
        prod = {{N{K[N-1]}}, K} * {{N{op[N-1]}}, op};
        mul_ovf = !(&prod[2*N-1:N+Q-1] || !(|prod[2*N-1:N+Q-1]));
        mul_res = SAT && mul_ovf ? (prod[2*N-1] ? MINV : MAXV) : prod[N+Q-1:Q];
        rem_sh = {rem, quot[N+Q-1]};
        rem_sub = rem_sh - {1'b0, dvs};
        ge = !rem_sub[N];
        rem_nxt = ge ? rem_sub[N-1:0] : rem_sh[N-1:0];
        quot_nxt = {quot[N+Q-2:0], ge};
        div_ovf = neg ? (|quot_nxt[N+Q-1:N] || (quot_nxt[N-1] && |quot_nxt[N-2:0])) : |quot_nxt[N+Q-1:N-1];
        div_res = SAT && div_ovf ? (neg ? MINV : MAXV) : (neg ? -quot_nxt[N-1:0] : quot_nxt[N-1:0]);
        unused = ^{prod[Q-1:0], rem_sh[N]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (valid_in) state_nxt = select[1:0] != 2'b00 ? MUL : select[2] ? DIV : DONE;
            MUL:  state_nxt = DONE;
            DIV:  if (zero || cnt == LAST) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            CORDIC_OUT <= '0;
            div0 <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (valid_in) begin
                    op <= select[0] ? y : x;
                    dvs <= x[N-1] ? -x : x;
                    quot <= {(y[N-1] ? -y : y), {Q{1'b0}}};
                    rem <= '0;
                    cnt <= '0;
                    neg <= x[N-1] ^ y[N-1];
                    zero <= x == '0;
                    ysgn <= y[N-1];
                    div0 <= 1'b0;
                    CORDIC_OUT <= angle;
                end
                MUL: CORDIC_OUT <= mul_res;
                DIV: if (zero) begin
                    CORDIC_OUT <= ysgn ? MINV : MAXV;
                    div0 <= 1'b1;
                end else begin
                    rem <= rem_nxt;
                    quot <= quot_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) CORDIC_OUT <= div_res;
                end
                default: ;
            endcase
        end
    end
endmodule
